// File: rtl/g20_pkg.sv
// g20_pkg: shared constants and types for the g20 bus master.
//   G20_*         default widths / depths / timeout
//   G20_WFLAG_BIT bit of QmAddr carrying the write flag
//   bm_state_t    bus-master FSM state encoding
package g20_pkg;

    localparam int G20_ADDR_W    = 48;
    localparam int G20_DATA_W    = 16;
    localparam int G20_MAX_BURST = 16;
    localparam int G20_GRANT_TO  = 64;

    localparam int G20_WFLAG_BIT = G20_ADDR_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_DATA,
        S_REQ,
        S_ADDR,
        S_DATA,
        S_FIN
    } bm_state_t;

endpackage

// File: rtl/g20_wfifo.sv
// g20_wfifo: synchronous show-ahead FIFO for buffered write data.
//   clk, rst     clock, asynchronous active-high reset
//   push/push_data  write port; ignored while full
//   pop          consume head word; ignored while empty
//   flush        drop all contents (wins over push/pop)
//   head         current head word (valid when count != 0)
//   count        number of stored words, 0..DEPTH
//   full         count == DEPTH
module g20_wfifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= ptr_next(wptr);
            if (do_pop)  rptr <= ptr_next(rptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/g20_bus_master.sv
// g20_bus_master: master-side agent for the g20 bus.
//   Client side: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len accept one
//   burst; wdata_valid/wdata/wdata_ready fill the write FIFO; rdata_valid/
//   rdata return read beats; done/err pulse once per command.
//   Bus side: request/itsyours handshake with the arbitrator, QmAddr carries
//   {write, addr} for one cycle, mdout/Mdin carry data, Xend ends transfer.
//   Qclock clock, BusReset asynchronous active-high reset.
module g20_bus_master
    import g20_pkg::*;
#(
    parameter int ADDR_W    = G20_ADDR_W,
    parameter int DATA_W    = G20_DATA_W,
    parameter int MAX_BURST = G20_MAX_BURST,
    parameter int GRANT_TO  = G20_GRANT_TO
) (
    input  logic                         Qclock,
    input  logic                         BusReset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_write,
    input  logic [ADDR_W-2:0]            cmd_addr,
    input  logic [$clog2(MAX_BURST)-1:0] cmd_len,
    input  logic                         wdata_valid,
    input  logic [DATA_W-1:0]            wdata,
    output logic                         wdata_ready,
    output logic                         rdata_valid,
    output logic [DATA_W-1:0]            rdata,
    output logic                         done,
    output logic                         err,
    output logic                         request,
    input  logic                         itsyours,
    output logic [ADDR_W-1:0]            QmAddr,
    output logic [DATA_W-1:0]            mdout,
    input  logic [DATA_W-1:0]            Mdin,
    input  logic                         Xend
);
    localparam int LEN_W  = $clog2(MAX_BURST);
    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int GCNT_W = $clog2(GRANT_TO + 1);

    bm_state_t          state;
    logic               cur_write;
    logic [ADDR_W-2:0]  cur_addr;
    logic [LEN_W-1:0]   cur_len;
    logic [CNT_W-1:0]   bcnt;       // beats already on the bus
    logic [GCNT_W-1:0]  gcnt;

    logic [CNT_W-1:0]   beats, bcnt_now;
    logic               in_data, rd_sample, beat_inc;
    logic               xfer_ok, xfer_abort;
    logic               fifo_pop, fifo_flush, fifo_full;
    logic [DATA_W-1:0]  fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic [ADDR_W-1:0]  bus_addr;

    g20_wfifo #(
        .DEPTH (MAX_BURST),
        .WIDTH (DATA_W)
    ) u_wfifo (
        .clk       (Qclock),
        .rst       (BusReset),
        .push      (wdata_valid),
        .push_data (wdata),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign wdata_ready = !fifo_full;
    assign cmd_ready   = (state == S_IDLE) && !BusReset;
    assign beats       = CNT_W'(cur_len) + CNT_W'(1);

    always_comb begin
        bus_addr                  = ADDR_W'(cur_addr);
        bus_addr[G20_WFLAG_BIT]   = cur_write;
    end

    // Transfer bookkeeping for the current DATA cycle. A write beat is
    // already on mdout (bcnt counts it); a read beat counts once Mdin is
    // taken this cycle, so the last beat and Xend may coincide.
    always_comb begin
        in_data    = (state == S_DATA);
        rd_sample  = in_data && !cur_write && itsyours && (bcnt < beats);
        fifo_pop   = cur_write && ((state == S_ADDR) ||
                     (in_data && !Xend && itsyours && (bcnt < beats)));
        beat_inc   = rd_sample || (in_data && fifo_pop);
        bcnt_now   = bcnt + CNT_W'(beat_inc);
        xfer_ok    = in_data && Xend && (bcnt_now == beats);
        xfer_abort = in_data && (Xend ? (bcnt_now != beats) : !itsyours);
        // Unsent beats of an aborted write must not leak into the next burst.
        fifo_flush = cur_write && xfer_abort;
    end

    always_ff @(posedge Qclock or posedge BusReset) begin
        if (BusReset) begin
            state       <= S_IDLE;
            cur_write   <= 1'b0;
            cur_addr    <= '0;
            cur_len     <= '0;
            bcnt        <= '0;
            gcnt        <= '0;
            request     <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            QmAddr      <= '0;
            mdout       <= '0;
        end else begin
            done        <= 1'b0;
            err         <= 1'b0;
            rdata_valid <= 1'b0;
            if (rd_sample) begin
                rdata       <= Mdin;
                rdata_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cur_write <= cmd_write;
                        cur_addr  <= cmd_addr;
                        cur_len   <= cmd_len;
                        state     <= cmd_write ? S_WAIT_DATA : S_REQ;
                    end
                end
                S_WAIT_DATA: begin
                    if (fifo_count >= beats) state <= S_REQ;
                end
                S_REQ: begin
                    request <= 1'b1;
                    // Grant only counts once our request is visible.
                    if (request && itsyours) begin
                        gcnt   <= '0;
                        QmAddr <= bus_addr;
                        state  <= S_ADDR;
                    end else if (request && (gcnt == GCNT_W'(GRANT_TO - 1))) begin
                        gcnt    <= '0;
                        request <= 1'b0;
                        err     <= 1'b1;
                        state   <= S_IDLE;
                    end else if (request) begin
                        gcnt <= gcnt + GCNT_W'(1);
                    end
                end
                S_ADDR: begin
                    QmAddr <= '0;
                    bcnt   <= cur_write ? CNT_W'(1) : '0;
                    if (cur_write) mdout <= fifo_head;
                    state  <= S_DATA;
                end
                S_DATA: begin
                    if (xfer_ok || xfer_abort) begin
                        request <= 1'b0;
                        mdout   <= '0;
                        bcnt    <= '0;
                        done    <= xfer_ok;
                        err     <= xfer_abort;
                        state   <= xfer_ok ? S_FIN : S_IDLE;
                    end else begin
                        bcnt <= bcnt_now;
                        if (cur_write) mdout <= fifo_pop ? fifo_head : '0;
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_g20_bus_master.sv
// Scoreboard bench for g20_bus_master: stimulus pushes expected bus
// addresses, write beats, read beats and done/err events into queues; a
// negedge monitor pops and compares whenever the DUT shows them.
module tb_g20_bus_master;
    import g20_pkg::*;

    logic                     Qclock = 1'b0;
    logic                     BusReset;
    logic                     cmd_valid, cmd_ready, cmd_write;
    logic [G20_ADDR_W-2:0]    cmd_addr;
    logic [3:0]               cmd_len;
    logic                     wdata_valid, wdata_ready;
    logic [G20_DATA_W-1:0]    wdata, rdata, mdout, Mdin;
    logic                     rdata_valid, done, err, request, itsyours, Xend;
    logic [G20_ADDR_W-1:0]    QmAddr;

    int n_chk  = 0;
    int n_pass = 0;

    logic [G20_ADDR_W-1:0] exp_addr [$];
    logic [G20_DATA_W-1:0] exp_md   [$];
    logic [G20_DATA_W-1:0] exp_rd   [$];
    logic [1:0]            exp_evt  [$];   // {done, err}
    logic [G20_DATA_W-1:0] md_src   [$];   // Mdin per DATA cycle

    g20_bus_master dut (
        .Qclock(Qclock), .BusReset(BusReset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
        .request(request), .itsyours(itsyours), .QmAddr(QmAddr),
        .mdout(mdout), .Mdin(Mdin), .Xend(Xend)
    );

    always #5 Qclock = ~Qclock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bad(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    task automatic tick();
        @(posedge Qclock);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge Qclock);
            if (BusReset !== 1'b0) continue;
            if (QmAddr != '0) begin
                if (exp_addr.size() == 0) bad("qmaddr_extra", QmAddr);
                else chk("qmaddr", QmAddr, exp_addr.pop_front());
            end
            if (mdout != '0) begin
                if (exp_md.size() == 0) bad("mdout_extra", mdout);
                else chk("mdout", mdout, exp_md.pop_front());
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) bad("rdata_extra", rdata);
                else chk("rdata", rdata, exp_rd.pop_front());
            end
            if (done || err) begin
                if (exp_evt.size() == 0) bad("event_extra", {done, err});
                else chk("done_err", {done, err}, exp_evt.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [15:0] w);
        wdata_valid = 1'b1;
        wdata       = w;
        tick();
        wdata_valid = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [46:0] a, input logic [3:0] len);
        int n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) begin bad("cmd_ready_timeout", cmd_ready); return; end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Arbitrator + slave model: grant after gdelay cycles, then end the
    // transfer (Xend, or grant removal when preempt) in DATA cycle last_cyc.
    task automatic bus_run(input string tag, input int gdelay, input int last_cyc,
                           input bit preempt);
        int n = 0;
        while (!request && n < 200) begin tick(); n++; end
        if (!request) begin bad({tag, "_req_timeout"}, request); return; end
        repeat (gdelay) tick();
        itsyours = 1'b1;
        tick();                      // now in ADDR
        chk({tag, "_req_in_addr"}, request, 1'b1);
        tick();                      // now in DATA cycle 0
        for (int c = 0; c <= last_cyc; c++) begin
            Mdin = (md_src.size() != 0) ? md_src.pop_front() : '0;
            if (c == last_cyc) begin
                if (preempt) itsyours = 1'b0;
                else         Xend     = 1'b1;
            end
            tick();
        end
        Xend = 1'b0; itsyours = 1'b0; Mdin = '0;
        chk({tag, "_req_low"}, request, 1'b0);
    endtask

    initial begin
        int cnt;
        BusReset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; wdata_valid = 1'b0; wdata = '0; itsyours = 1'b0;
        Mdin = '0; Xend = 1'b0;
        #3;
        chk("rst_request", request, 0);
        chk("rst_done_err", {done, err, rdata_valid}, 0);
        chk("rst_qmaddr", QmAddr, 0);
        chk("rst_mdout_rdata", {mdout, rdata}, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        tick(); tick();
        BusReset = 1'b0;
        #1;
        chk("cmd_ready_idle", cmd_ready, 1);

        // Write len=3, grant after 5 cycles
        for (int i = 1; i <= 4; i++) push(16'hA000 + 16'(i));
        exp_addr.push_back({1'b1, 47'h123456789AB});
        for (int i = 1; i <= 4; i++) exp_md.push_back(16'hA000 + 16'(i));
        exp_evt.push_back(2'b10);
        issue(1'b1, 47'h123456789AB, 4'd3);
        bus_run("wr4", 5, 3, 1'b0);

        // Read len=1
        md_src.push_back(16'h5A5A); md_src.push_back(16'hC3C3);
        exp_addr.push_back({1'b0, 47'h0ABC});
        exp_rd.push_back(16'h5A5A); exp_rd.push_back(16'hC3C3);
        exp_evt.push_back(2'b10);
        issue(1'b0, 47'h0ABC, 4'd1);
        bus_run("rd2", 2, 1, 1'b0);

        // Grant never comes
        exp_evt.push_back(2'b01);
        issue(1'b0, 47'h42, 4'd0);
        cnt = 0;
        while (!request && cnt < 50) begin tick(); cnt++; end
        cnt = 0;
        while (request && cnt < 200) begin tick(); cnt++; end
        chk("grant_timeout_len", cnt, G20_GRANT_TO);
        md_src.push_back(16'h1234);
        exp_addr.push_back({1'b0, 47'h43});
        exp_rd.push_back(16'h1234);
        exp_evt.push_back(2'b10);
        issue(1'b0, 47'h43, 4'd0);
        bus_run("rd_after_to", 1, 0, 1'b0);

        // Write len=7 waits for all eight words
        for (int i = 1; i <= 4; i++) push(16'hB000 + 16'(i));
        issue(1'b1, 47'h55, 4'd7);
        repeat (10) tick();
        chk("wait_data_no_req", request, 0);
        chk("wait_data_busy", cmd_ready, 0);
        for (int i = 5; i <= 8; i++) push(16'hB000 + 16'(i));
        cnt = 0;
        while (!request && cnt < 4) begin tick(); cnt++; end
        chk("wait_data_req", request, 1);
        exp_addr.push_back({1'b1, 47'h55});
        for (int i = 1; i <= 8; i++) exp_md.push_back(16'hB000 + 16'(i));
        exp_evt.push_back(2'b10);
        bus_run("wr8", 0, 7, 1'b0);

        // Early Xend on a write: two beats sent, rest flushed
        for (int i = 1; i <= 8; i++) push(16'hC000 + 16'(i));
        exp_addr.push_back({1'b1, 47'h66});
        exp_md.push_back(16'hC001); exp_md.push_back(16'hC002);
        exp_evt.push_back(2'b01);
        issue(1'b1, 47'h66, 4'd7);
        bus_run("wr_early", 1, 1, 1'b0);
        push(16'hD00D);
        exp_addr.push_back({1'b1, 47'h67});
        exp_md.push_back(16'hD00D);
        exp_evt.push_back(2'b10);
        issue(1'b1, 47'h67, 4'd0);
        bus_run("wr_after_flush", 0, 0, 1'b0);

        // Grant removed mid-read: one beat, err, no done
        md_src.push_back(16'h1111); md_src.push_back(16'h2222);
        exp_addr.push_back({1'b0, 47'h77});
        exp_rd.push_back(16'h1111);
        exp_evt.push_back(2'b01);
        issue(1'b0, 47'h77, 4'd3);
        bus_run("rd_preempt", 0, 1, 1'b1);

        // FIFO full boundary; the overflow word must be dropped
        for (int i = 0; i < 15; i++) push(16'hE000 + 16'(i));
        chk("wready_15", wdata_ready, 1);
        push(16'hE00F);
        chk("wready_full", wdata_ready, 0);
        push(16'hE0FF);
        exp_addr.push_back({1'b1, 47'h88});
        for (int i = 0; i < 16; i++) exp_md.push_back(16'hE000 + 16'(i));
        exp_evt.push_back(2'b10);
        issue(1'b1, 47'h88, 4'd15);
        bus_run("wr16", 0, 15, 1'b0);
        push(16'hF00D);
        exp_addr.push_back({1'b1, 47'h89});
        exp_md.push_back(16'hF00D);
        exp_evt.push_back(2'b10);
        issue(1'b1, 47'h89, 4'd0);
        bus_run("wr_after_full", 0, 0, 1'b0);

        // Reset in the middle of DATA
        for (int i = 1; i <= 4; i++) push(16'h7000 + 16'(i));
        exp_addr.push_back({1'b1, 47'h99});
        exp_md.push_back(16'h7001); exp_md.push_back(16'h7002);
        issue(1'b1, 47'h99, 4'd3);
        cnt = 0;
        while (!request && cnt < 20) begin tick(); cnt++; end
        itsyours = 1'b1;
        tick(); tick(); tick();       // ADDR, DATA 0, DATA 1
        #6;
        BusReset = 1'b1;
        #1;
        chk("mid_rst_request", request, 0);
        chk("mid_rst_mdout", mdout, 0);
        chk("mid_rst_qmaddr", QmAddr, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        itsyours = 1'b0;
        tick();
        BusReset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        push(16'h7777);
        exp_addr.push_back({1'b1, 47'h9A});
        exp_md.push_back(16'h7777);
        exp_evt.push_back(2'b10);
        issue(1'b1, 47'h9A, 4'd0);
        bus_run("wr_after_rst", 0, 0, 1'b0);

        repeat (5) tick();
        chk("left_addr", exp_addr.size(), 0);
        chk("left_mdout", exp_md.size(), 0);
        chk("left_rdata", exp_rd.size(), 0);
        chk("left_event", exp_evt.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
